// File: rtl/pattern_pkg.sv
// pattern_pkg: shared state type, default widths and pointer-width helper
// for the pattern acknowledge path.
package pattern_pkg;
  typedef enum logic [1:0] {IDLE, RUN, ACK_LOW, RELEASE} state_t;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/match_index_fifo.sv
// match_index_fifo: show-ahead FIFO with registered flags; a push into a full
// FIFO without a simultaneous pop is dropped and reported on drop for one cycle.
module match_index_fifo
  import pattern_pkg::*;
#(
  parameter int WIDTH = DEF_IDX_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] used, used_next;
  logic do_pop, do_push;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop = push && full && !do_pop;
  assign used_next = used + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      used <= used_next;
      empty <= used_next == '0;
      full <= used_next == (PW+1)'(DEPTH);
    end
endmodule

// File: rtl/pattern_ack_controller.sv
// pattern_ack_controller: acknowledges detector matches with a low pulse on ack,
// counts matches (saturating) and logs each match's byte index into a FIFO.
module pattern_ack_controller
  import pattern_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ACK_LOW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             data_valid,
  input  logic             found_pattern,
  input  logic             rd_en,
  output logic             ack,
  output logic [CNT_W-1:0] match_count,
  output logic [IDX_W-1:0] fifo_dout,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow
);
  localparam int LW = ptr_w(ACK_LOW_CYCLES) + 1;
  state_t state;
  logic [IDX_W-1:0] byte_idx;
  logic [LW-1:0] low_cnt;
  logic push, drop;
  assign push = state == RUN && found_pattern;
  match_index_fifo #(.WIDTH(IDX_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst_n(reset_sync),
    .push(push),
    .pop(rd_en),
    .din(byte_idx),
    .dout(fifo_dout),
    .empty(fifo_empty),
    .full(fifo_full),
    .drop(drop)
  );
  // ack is registered alongside state so it changes on the same edge
  always_ff @(posedge clk or negedge reset_sync)
    if (!reset_sync) begin
      state <= IDLE;
      ack <= 1'b0;
      byte_idx <= '0;
      low_cnt <= '0;
      match_count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | drop;
      case (state)
        IDLE: begin
          state <= RUN;
          ack <= 1'b1;
        end
        RUN:
          if (found_pattern) begin
            state <= ACK_LOW;
            ack <= 1'b0;
            low_cnt <= LW'(ACK_LOW_CYCLES - 1);
            match_count <= match_count + CNT_W'(match_count != '1);
          end else if (data_valid) byte_idx <= byte_idx + IDX_W'(1);
        ACK_LOW:
          if (low_cnt != '0) low_cnt <= low_cnt - LW'(1);
          else begin
            state <= RELEASE;
            ack <= 1'b1;
          end
        default:
          if (!found_pattern) state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_pattern_ack_controller.sv
// tb_pattern_ack_controller: two instances (default, and ack-low 3 / 2-bit count)
// checked every cycle against a behavioural model plus directed literal checks.
module tb_pattern_ack_controller;
  localparam int D = 4;
  logic clk = 1'b0, reset_sync = 1'b0, data_valid = 1'b0, found_pattern = 1'b0, rd_en = 1'b0;
  logic ack0, ack1, empty0, empty1, full0, full1, ovf0, ovf1;
  logic [7:0] cnt0, dout0, dout1;
  logic [1:0] cnt1;
  int checks = 0, errors = 0, low0 = 0, low1 = 0;
  int ph[2], lo[2], idx[2], cnt[2], fn[2], fq[2][D];
  bit mov[2];
  int lcyc[2] = '{1, 3};
  int cmax[2] = '{255, 3};
  always #5 clk = ~clk;

  pattern_ack_controller dut0 (
    .clk(clk), .reset_sync(reset_sync), .data_valid(data_valid), .found_pattern(found_pattern),
    .rd_en(rd_en), .ack(ack0), .match_count(cnt0), .fifo_dout(dout0), .fifo_empty(empty0),
    .fifo_full(full0), .overflow(ovf0)
  );
  pattern_ack_controller #(.ACK_LOW_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .reset_sync(reset_sync), .data_valid(data_valid), .found_pattern(found_pattern),
    .rd_en(rd_en), .ack(ack1), .match_count(cnt1), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_full(full1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Phases: 0 not started, 1 running, 2 acknowledging (lo cycles left), 3 waiting for match to drop
  always @(posedge clk or negedge reset_sync)
    if (!reset_sync) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0; lo[k] = 0; idx[k] = 0; cnt[k] = 0; fn[k] = 0; mov[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit pop, push;
        int pv;
        pop = rd_en && fn[k] > 0;
        push = ph[k] == 1 && found_pattern;
        pv = idx[k];
        if (ph[k] == 0) ph[k] = 1;
        else if (ph[k] == 1) begin
          if (found_pattern) begin
            if (cnt[k] < cmax[k]) cnt[k]++;
            lo[k] = lcyc[k];
            ph[k] = 2;
          end else if (data_valid) idx[k] = (idx[k] + 1) % 256;
        end else if (ph[k] == 2) begin
          lo[k]--;
          if (lo[k] == 0) ph[k] = 3;
        end else if (!found_pattern) ph[k] = 1;
        if (pop) begin
          for (int j = 0; j < D - 1; j++) fq[k][j] = fq[k][j+1];
          fn[k]--;
        end
        if (push) begin
          if (fn[k] < D) begin
            fq[k][fn[k]] = pv;
            fn[k]++;
          end else mov[k] = 1;
        end
      end
    end

  task automatic cmp(input int k, input logic a, input logic [7:0] c, input logic [7:0] d,
                     input logic e, input logic f, input logic o);
    chk($sformatf("ack%0d", k), a, ph[k] == 1 || ph[k] == 3);
    chk($sformatf("count%0d", k), c, cnt[k]);
    chk($sformatf("empty%0d", k), e, fn[k] == 0);
    chk($sformatf("full%0d", k), f, fn[k] == D);
    chk($sformatf("overflow%0d", k), o, mov[k]);
    if (fn[k] > 0) chk($sformatf("dout%0d", k), d, fq[k][0]);
    if (!reset_sync) chk($sformatf("reset_dout%0d", k), d, 0);
  endtask

  always @(negedge clk) begin
    cmp(0, ack0, cnt0, dout0, empty0, full0, ovf0);
    cmp(1, ack1, {6'd0, cnt1}, dout1, empty1, full1, ovf1);
    if (reset_sync && !ack0) low0++;
    if (reset_sync && !ack1) low1++;
  end

  task automatic cyc(input logic dv, input logic fp, input logic rd);
    @(negedge clk);
    #1;
    data_valid = dv;
    found_pattern = fp;
    rd_en = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_sync = 1'b0;
    data_valid = 1'b0;
    found_pattern = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_sync = 1'b1;
  endtask

  task automatic match_at_plus2();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    idle(5);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] v);
    chk(name, dout0, v);
    chk({name, "_b"}, dout1, v);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  initial begin
    // reset release
    do_reset();
    chk("rel_ack0_first", ack0, 0);
    chk("rel_ack1_first", ack1, 0);
    chk("rel_count0", cnt0, 0);
    chk("rel_empty0", empty0, 1);
    chk("rel_dout0", dout0, 0);
    idle(1);
    chk("rel_ack0_second", ack0, 1);
    chk("rel_ack1_second", ack1, 1);
    // single match after 5 bytes
    repeat (5) cyc(1, 0, 0);
    low0 = 0;
    low1 = 0;
    cyc(1, 1, 0);
    idle(6);
    chk("single_low0", low0, 1);
    chk("single_low1", low1, 3);
    chk("single_dout0", dout0, 5);
    chk("single_count0", cnt0, 1);
    chk("single_empty0", empty0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("single_pop_empty0", empty0, 1);
    chk("single_pop_empty1", empty1, 1);
    // match held for 6 cycles
    low0 = 0;
    low1 = 0;
    repeat (6) cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 0);
    chk("held_low1", low1, 3);
    chk("held_low0", low0, 1);
    chk("held_count0", cnt0, 2);
    chk("held_count1", cnt1, 2);
    cyc(1, 1, 0);
    idle(6);
    pop_expect("held_first", 5);
    pop_expect("held_second", 8);
    chk("held_empty0", empty0, 1);
    // overflow: matches at 2,4,6,8,10, no reads
    do_reset();
    repeat (5) match_at_plus2();
    chk("ovf_full0", full0, 1);
    chk("ovf_flag0", ovf0, 1);
    chk("ovf_count0", cnt0, 5);
    chk("sat_count1", cnt1, 3);
    pop_expect("ovf_pop1", 2);
    pop_expect("ovf_pop2", 4);
    pop_expect("ovf_pop3", 6);
    pop_expect("ovf_pop4", 8);
    chk("ovf_empty0", empty0, 1);
    chk("ovf_sticky0", ovf0, 1);
    // simultaneous push and pop while full
    do_reset();
    repeat (4) match_at_plus2();
    chk("pp_full_before", full0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    idle(5);
    chk("pp_full0", full0, 1);
    chk("pp_ovf0", ovf0, 0);
    chk("pp_ovf1", ovf1, 0);
    pop_expect("pp_pop1", 4);
    pop_expect("pp_pop2", 6);
    pop_expect("pp_pop3", 8);
    pop_expect("pp_pop4", 10);
    chk("pp_empty0", empty0, 1);
    // reset during ACK_LOW
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("mid_ack0_low", ack0, 0);
    chk("mid_count0", cnt0, 6);
    reset_sync = 1'b0;
    #1;
    chk("async_ack0", ack0, 0);
    chk("async_ack1", ack1, 0);
    chk("async_empty0", empty0, 1);
    chk("async_count0", cnt0, 0);
    chk("async_count1", cnt1, 0);
    repeat (2) @(negedge clk);
    #1;
    reset_sync = 1'b1;
    repeat (5) match_at_plus2();
    chk("sat2_count1", cnt1, 3);
    chk("sat2_count0", cnt0, 5);
    chk("sat2_dout0", dout0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_ack_controller.md
Name: pattern_ack_controller

Overview:
Downstream companion to the pattern detector. It consumes `found_pattern`, drives the detector's `ack` handshake, counts matches, and logs the stream byte index of each match into a small show-ahead FIFO for host readout. It sits between the detector and the host/debug interface, on the detector's clock.

Parameters:
- IDX_W, 8, width of the byte-index counter and of the FIFO entries; the index wraps modulo 2^IDX_W.
- CNT_W, 8, width of the match counter; the counter saturates.
- FIFO_DEPTH, 4, number of match-index entries; must be a power of two and at least 2.
- ACK_LOW_CYCLES, 1, number of cycles `ack` is held low per match; must be at least 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset_sync, input, 1, asynchronous, active-low reset.
- data_valid, input, 1, a byte is presented to the detector this cycle.
- found_pattern, input, 1, match flag from the detector.
- rd_en, input, 1, pop the FIFO head.
- ack, output, 1, handshake to the detector; 1 means running, a low pulse acknowledges a match.
- match_count, output, CNT_W, number of matches seen; saturating.
- fifo_dout, output, IDX_W, FIFO head entry; show-ahead, valid when fifo_empty=0.
- fifo_empty, output, 1, FIFO holds no entries.
- fifo_full, output, 1, FIFO holds FIFO_DEPTH entries.
- overflow, output, 1, sticky flag: a match was dropped because the FIFO was full.

Behaviour:
- Reset (reset_sync=0, asynchronous):
  - Outputs: ack=0, match_count=0, fifo_empty=1, fifo_full=0, overflow=0, fifo_dout=0.
  - Internal: byte_idx=0, FIFO pointers=0, state=IDLE.
- State machine (registered; ack is a registered output decoded from state):
  - IDLE: ack=0. Moves unconditionally to RUN on the first clock after reset deasserts.
  - RUN: ack=1.
    - If found_pattern=1: push byte_idx, increment match_count, load the low-counter with ACK_LOW_CYCLES-1, go to ACK_LOW.
    - Else if data_valid=1: byte_idx increments by 1, wrapping.
  - ACK_LOW: ack=0. While the low-counter is nonzero it decrements. When it reaches 0, go to RELEASE.
  - RELEASE: ack=1. Stay until found_pattern=0, then go to RUN.
    - byte_idx does not advance in RELEASE.
    - A match still asserted in RELEASE is the same match: no new push, no new count.
- Latency and timing:
  - found_pattern sampled high in RUN produces ack=0 on the next cycle.
  - ack stays low for exactly ACK_LOW_CYCLES cycles.
  - In ACK_LOW, byte_idx is frozen and found_pattern is ignored.
- Recorded index: the value of byte_idx in the RUN cycle where found_pattern is sampled high. This equals the number of bytes accepted before the match.
- match_count: increments once per RUN→ACK_LOW transition. It holds at 2^CNT_W−1 once it gets there.
- FIFO:
  - fifo_dout shows the head entry combinationally from storage.
  - Pop occurs on rd_en=1 with fifo_empty=0; rd_en while empty is ignored and has no effect.
  - Push while full, with no pop in the same cycle: the entry is dropped, overflow sets to 1 and stays set until reset. match_count still increments.
  - Push and pop in the same cycle while full: both happen, occupancy is unchanged, overflow stays unchanged.
  - Push and pop in the same cycle while empty: the push happens and the pop is ignored. The new entry is visible the next cycle.
  - fifo_full and fifo_empty are registered and derived from occupancy after the update.
- Reset asserted in the middle of any state: every register returns to its reset value immediately. FIFO contents are discarded.

Decomposition:
- Shared package `pattern_pkg`:
  - State enum {IDLE, RUN, ACK_LOW, RELEASE}, 2 bits.
  - Default constants for IDX_W, CNT_W, FIFO_DEPTH.
  - A clog2-based pointer-width helper.
- One sub-module, `match_index_fifo`: parameterised by width and depth, show-ahead, registered full/empty, drop-on-full with an overflow pulse output. The top-level makes overflow sticky.
- The FSM, byte-index counter and match counter live in the top-level.

Test Plan:
- Reset release: hold reset_sync=0 for 2 cycles, then release. Required: ack=0 in the first cycle after release, ack=1 in the second; match_count=0, fifo_empty=1.
- Single match: with data_valid=1 every cycle, assert found_pattern after 5 bytes accepted. Required: ack low for exactly 1 cycle; then fifo_dout=5, match_count=1, fifo_empty=0; a single rd_en pulse gives fifo_empty=1.
- Long ACK_LOW and held match: with ACK_LOW_CYCLES=3, hold found_pattern high for 6 cycles. Required: ack low for exactly 3 cycles; exactly one push, match_count=1; byte_idx resumes only after found_pattern=0.
- Overflow: with FIFO_DEPTH=4, generate 5 matches at indices 2, 4, 6, 8, 10 with no reads. Required: fifo_full=1, overflow=1, match_count=5; pops return 2, 4, 6, 8, then fifo_empty=1.
- Simultaneous push/pop while full: FIFO holds 4 entries; assert rd_en in the cycle a match is pushed. Required: the oldest entry is popped, the new index is appended, fifo_full stays 1, overflow stays 0.
- Reset mid-operation and saturation:
  - Assert reset_sync=0 during ACK_LOW. Required: ack=0 immediately, FIFO empty, match_count=0.
  - Then, with CNT_W=2, 5 matches. Required: match_count holds at 3.
